// File: rtl/hermes_switch_control.sv
// -----------------------------------------------------------------------------
// hermes_switch_control
//
// Control unit of one Hermes mesh router. Header requests from the five input
// buffers (EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4) are served round-robin.
// Each granted header is XY-routed, its output port is reserved, and the
// crossbar selection table is updated. A connection is torn down as soon as
// its source buffer stops sending.
//
// Each request walks S_IDLE -> S_ARB -> S_ROUTE -> S_GRANT, so there is at
// most one grant every four cycles.
//
// Parameters:
//   FLIT_WIDTH  flit width; the x and y address fields are FLIT_WIDTH/4 bits
//   ADDRESS     router address, x in [FLIT_WIDTH/2-1:FLIT_WIDTH/4],
//               y in [FLIT_WIDTH/4-1:0]
//
// Ports:
//   clock        core clock, rising-edge active
//   reset        asynchronous active-low reset
//   h[4:0]       input buffer p holds a header and requests routing
//   sender[4:0]  input buffer p is still transmitting its packet
//   data_in      header flit of port p at [p*FLIT_WIDTH +: FLIT_WIDTH]
//   ack_h[4:0]   one-cycle grant pulse back to input buffer p
//   mux_in[14:0] 3-bit source index per output o at [o*3 +: 3]
//   en_out[4:0]  output o is connected to an input
//   free_o[4:0]  output o is unreserved
//
// Optional feature, macro HERMES_SWITCH_STATS_EN:
//   grant_count[15:0]  counts S_GRANT cycles (wraps)
//   block_count[15:0]  counts requests bounced by a busy target (wraps)
// -----------------------------------------------------------------------------
module hermes_switch_control #(
    parameter int unsigned             FLIT_WIDTH = 32,
    parameter logic [FLIT_WIDTH/2-1:0] ADDRESS    = {(FLIT_WIDTH/2){1'b0}}
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [4:0]                h,
    input  logic [4:0]                sender,
    input  logic [5*FLIT_WIDTH-1:0]   data_in,
    output logic [4:0]                ack_h,
    output logic [14:0]               mux_in,
    output logic [4:0]                en_out,
    output logic [4:0]                free_o
`ifdef HERMES_SWITCH_STATS_EN
    ,
    output logic [15:0]               grant_count,
    output logic [15:0]               block_count
`endif
);

    localparam int unsigned AW = FLIT_WIDTH / 4;

    localparam logic [2:0] P_EAST  = 3'd0;
    localparam logic [2:0] P_WEST  = 3'd1;
    localparam logic [2:0] P_NORTH = 3'd2;
    localparam logic [2:0] P_SOUTH = 3'd3;
    localparam logic [2:0] P_LOCAL = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_ROUTE = 2'd2,
        S_GRANT = 2'd3
    } state_t;

    // Successor of a port index in the modulo-5 round-robin ring.
    function automatic logic [2:0] next_port(input logic [2:0] p);
        logic [2:0] n;
        case (p)
            3'd0:    n = 3'd1;
            3'd1:    n = 3'd2;
            3'd2:    n = 3'd3;
            3'd3:    n = 3'd4;
            3'd4:    n = 3'd0;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Unsigned XY routing decision: resolve x first, then y, else LOCAL.
    function automatic logic [2:0] xy_route(input logic [FLIT_WIDTH/2-1:0] xy);
        logic [AW-1:0] tx;
        logic [AW-1:0] ty;
        logic [AW-1:0] lx;
        logic [AW-1:0] ly;
        logic [2:0]    port;
        tx = xy[2*AW-1:AW];
        ty = xy[AW-1:0];
        lx = ADDRESS[2*AW-1:AW];
        ly = ADDRESS[AW-1:0];
        if (tx > lx) begin
            port = P_EAST;
        end else if (tx < lx) begin
            port = P_WEST;
        end else if (ty > ly) begin
            port = P_NORTH;
        end else if (ty < ly) begin
            port = P_SOUTH;
        end else begin
            port = P_LOCAL;
        end
        return port;
    endfunction

    // Looks up the sender flag of a source index; an out-of-range index reads
    // as idle so a corrupted table entry gets released rather than stuck.
    function automatic logic src_busy(input logic [4:0] snd, input logic [2:0] idx);
        logic b;
        case (idx)
            3'd0:    b = snd[0];
            3'd1:    b = snd[1];
            3'd2:    b = snd[2];
            3'd3:    b = snd[3];
            3'd4:    b = snd[4];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    state_t              state_q, state_d;
    logic [2:0]          rr_ptr_q, rr_ptr_d;
    logic [2:0]          sel_q, sel_d;
    logic [4:0]          ack_h_q, ack_h_d;
    logic [14:0]         mux_in_q, mux_in_d;
    logic [4:0]          en_out_q, en_out_d;
    logic [4:0]          free_o_q, free_o_d;

    logic                arb_found_s;
    logic [2:0]          arb_sel_s;
    logic [FLIT_WIDTH-1:0] hdr_sel_s;
    logic [2:0]          route_tgt_s;
    logic                unused_hdr_s;

    // Round-robin search starting one past the last winner.
    always_comb begin
        logic [2:0] cand;
        arb_found_s = 1'b0;
        arb_sel_s   = rr_ptr_q;
        cand        = rr_ptr_q;
        for (int k = 0; k < 5; k++) begin
            cand = next_port(cand);
            if (!arb_found_s && h[cand]) begin
                arb_found_s = 1'b1;
                arb_sel_s   = cand;
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Header flit of the currently selected input buffer.
    always_comb begin
        case (sel_q)
            3'd0:    hdr_sel_s = data_in[0*FLIT_WIDTH +: FLIT_WIDTH];
            3'd1:    hdr_sel_s = data_in[1*FLIT_WIDTH +: FLIT_WIDTH];
            3'd2:    hdr_sel_s = data_in[2*FLIT_WIDTH +: FLIT_WIDTH];
            3'd3:    hdr_sel_s = data_in[3*FLIT_WIDTH +: FLIT_WIDTH];
            3'd4:    hdr_sel_s = data_in[4*FLIT_WIDTH +: FLIT_WIDTH];
            default: hdr_sel_s = data_in[0*FLIT_WIDTH +: FLIT_WIDTH];
        endcase
    end

    assign route_tgt_s  = xy_route(hdr_sel_s[FLIT_WIDTH/2-1:0]);
    // Only the address half of the header is used for routing.
    assign unused_hdr_s = ^hdr_sel_s[FLIT_WIDTH-1:FLIT_WIDTH/2];

    // Next-state logic: connection release, then FSM arbitration/route/grant.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        ack_h_d  = 5'b00000;
        mux_in_d = mux_in_q;
        en_out_d = en_out_q;
        free_o_d = free_o_q;

        // Releases run every cycle regardless of the FSM. A grant target was
        // free in free_o_q, so it is never also a release candidate.
        for (int o = 0; o < 5; o++) begin
            if (en_out_q[o] && !src_busy(sender, mux_in_q[o*3 +: 3])) begin
                en_out_d[o] = 1'b0;
                free_o_d[o] = 1'b1;
            end else begin
                en_out_d[o] = en_out_q[o];
                free_o_d[o] = free_o_q[o];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (|h) begin
                    state_d = S_ARB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARB: begin
                if (arb_found_s) begin
                    sel_d    = arb_sel_s;
                    rr_ptr_d = arb_sel_s;
                    state_d  = S_ROUTE;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_ROUTE: begin
                // Grant updates land on the edge into S_GRANT so that ack_h
                // and the reserved connection are visible during S_GRANT.
                if (free_o_q[route_tgt_s]) begin
                    state_d                      = S_GRANT;
                    ack_h_d[sel_q]               = 1'b1;
                    mux_in_d[route_tgt_s*3 +: 3] = sel_q;
                    en_out_d[route_tgt_s]        = 1'b1;
                    free_o_d[route_tgt_s]        = 1'b0;
                end else begin
                    // Busy target: drop back; rr_ptr already moved past the
                    // requester, so other inputs get their turn first.
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= P_LOCAL;
            sel_q    <= P_EAST;
            ack_h_q  <= 5'b00000;
            mux_in_q <= 15'd0;
            en_out_q <= 5'b00000;
            free_o_q <= 5'b11111;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            ack_h_q  <= ack_h_d;
            mux_in_q <= mux_in_d;
            en_out_q <= en_out_d;
            free_o_q <= free_o_d;
        end
    end

    assign ack_h  = ack_h_q;
    assign mux_in = mux_in_q;
    assign en_out = en_out_q;
    assign free_o = free_o_q;

`ifdef HERMES_SWITCH_STATS_EN
    logic [15:0] grant_count_q, grant_count_d;
    logic [15:0] block_count_q, block_count_d;

    // Wrapping grant / blocked-route event counters.
    always_comb begin
        grant_count_d = grant_count_q;
        block_count_d = block_count_q;
        if (state_q == S_GRANT) begin
            grant_count_d = grant_count_q + 16'd1;
        end else begin
            grant_count_d = grant_count_q;
        end
        if ((state_q == S_ROUTE) && !free_o_q[route_tgt_s]) begin
            block_count_d = block_count_q + 16'd1;
        end else begin
            block_count_d = block_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_count_q <= 16'd0;
            block_count_q <= 16'd0;
        end else begin
            grant_count_q <= grant_count_d;
            block_count_q <= block_count_d;
        end
    end

    assign grant_count = grant_count_q;
    assign block_count = block_count_q;
`endif

endmodule

// File: doc/hermes_switch_control.md
Name: hermes_switch_control

Overview:
- Per-router control unit for the Hermes mesh router used in each manycore PE.
- Takes header requests from the five input buffers (EAST, WEST, NORTH, SOUTH, LOCAL) and arbitrates them round-robin.
- Computes the XY route for each granted header, reserves the output port and drives the crossbar selection table.
- Frees each connection when its source buffer finishes sending the packet.

Parameters:
- FLIT_WIDTH, 32, flit width in bits; address fields are FLIT_WIDTH/4 bits each.
- ADDRESS, 0, router address: x in bits [FLIT_WIDTH/2-1:FLIT_WIDTH/4], y in bits [FLIT_WIDTH/4-1:0].

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- h  in  5  bit p = input buffer p holds a header flit and requests routing.
- sender  in  5  bit p = input buffer p is still transmitting its current packet.
- data_in  in  5*FLIT_WIDTH  header flit of port p at slice [p*FLIT_WIDTH +: FLIT_WIDTH].
- ack_h  out  5  one-cycle grant pulse to input buffer p.
- mux_in  out  15  3-bit source input index per output o, at [o*3 +: 3].
- en_out  out  5  output o is connected to an input.
- free_o  out  5  output o is unreserved.

Behaviour:
- Port encoding: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.
- Reset is asynchronous and active-low. While reset is low:
  - ack_h=0, mux_in=0, en_out=0, free_o=5'b11111.
  - FSM=S_IDLE, rr_ptr=4, so the first search starts at EAST.
- FSM states: S_IDLE, S_ARB, S_ROUTE, S_GRANT.
- S_IDLE: if any h bit is set, go to S_ARB; otherwise stay.
- S_ARB: register sel = first p with h[p]=1, searching rr_ptr+1, rr_ptr+2, ... modulo 5. Set rr_ptr=sel. Go to S_ROUTE.
  - If h has dropped to all-zero by this cycle, return to S_IDLE.
- S_ROUTE: decode target x/y from data_in[sel] and register tgt:
  - tx>lx gives EAST; tx<lx gives WEST.
  - Otherwise ty>ly gives NORTH; ty<ly gives SOUTH.
  - Otherwise LOCAL.
  - Comparisons are unsigned, FLIT_WIDTH/4 bits wide.
  - If free_o[tgt]=1 go to S_GRANT; otherwise go to S_IDLE. The blocked requester is retried later and does not starve others.
- S_GRANT, same edge for all updates:
  - ack_h[sel]=1 for exactly this cycle.
  - mux_in[tgt]=sel, en_out[tgt]=1, free_o[tgt]=0.
  - Next state is S_IDLE.
- Latency: h rises while in S_IDLE → ack_h asserted in the 4th cycle (IDLE, ARB, ROUTE, GRANT) when the target is free.
- Throughput: at most one grant per 4 cycles.
- Release: evaluated every cycle, independent of the FSM.
  - For each o with en_out[o]=1 and sender[mux_in[o]]=0: en_out[o]=0 and free_o[o]=1 at the next edge.
  - Multiple releases may occur in the same cycle.
- Simultaneous release and ROUTE check on the same port: ROUTE uses the registered free_o, so it sees the port busy. The request is retried; the port is never double-granted.
- mux_in[o] keeps its last value after release; it is only meaningful while en_out[o]=1.
- A route whose target equals the arrival port is still granted. Malformed headers are the source's responsibility.
- An asynchronous reset mid-operation aborts the FSM immediately, drops all connections and frees all outputs. No ack_h pulse survives the reset.

Optional Feature:
- Macro: HERMES_SWITCH_STATS_EN.
- When defined, two extra ports are added:
  - grant_count (out, 16): increments on each S_GRANT cycle.
  - block_count (out, 16): increments on each S_ROUTE→S_IDLE transition caused by a busy target.
  - Both wrap modulo 2^16 and reset to 0.
- When undefined, neither the ports nor the counters exist, and the remaining behaviour is identical.

Test Plan:
- ADDRESS=16'h0101, data_in[LOCAL]=32'h0201, h[4]=1 at cycle 0 → ack_h[4]=1 in cycle 3 only; mux_in[0+:3]=4, en_out[0]=1, free_o[0]=0.
- Same ADDRESS, headers 32'h0101 on WEST, 32'h0100 on NORTH, 32'h0001 on EAST → targets LOCAL, SOUTH, WEST respectively.
- h=5'b11111, all five targets distinct and free → grants in order EAST, WEST, NORTH, SOUTH, LOCAL, spaced 4 cycles apart.
- WEST and SOUTH both target LOCAL → WEST granted first; SOUTH is blocked repeatedly (block_count increments when the macro is enabled). Drop sender[1] → free_o[4]=1 the next cycle, then SOUTH is granted.
- Grant EAST, then assert reset low in the middle of a second request's S_ROUTE → all outputs at reset values immediately, no ack_h pulse. Release reset → the second request restarts from S_IDLE.
- HERMES_SWITCH_STATS_EN defined, 65537 grants issued → grant_count=1 (wrap-around check).
